// File: rtl/arith_pkg.sv
// Shared arithmetic-block definitions: FSM encoding for the bit-serial subtractor.
package arith_pkg;
  localparam int ST_W = 2;

  typedef enum logic [ST_W-1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } sub_state_t;
endpackage

// File: rtl/sub_serial_full_subtractor.sv
// One-bit full subtractor: D = A - B - Bin, with borrow out. Dual of the full-adder cell.
module full_subtractor (
  input  logic A,
  input  logic B,
  input  logic Bin,
  output logic D,
  output logic Bout
);
  assign D    = A ^ B ^ Bin;
  assign Bout = (~A & B) | (~(A ^ B) & Bin);
endmodule

// File: rtl/sub_serial.sv
// Bit-serial subtractor: D = A - B - Bin over WIDTH clocks, LSB first, start/busy/done handshake.
module sub_serial
  import arith_pkg::*;
#(
  parameter  int WIDTH = 4,
  localparam int CW    = $clog2(WIDTH + 1)
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             Start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] D,
  output logic             Bout,
  output logic             Zero
);
  sub_state_t       state_q, state_d;
  logic [WIDTH-1:0] opa_q, opa_d, opb_q, opb_d, acc_q, acc_d;
  logic [WIDTH-1:0] dres_q, dres_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             br_q, br_d, bout_q, bout_d, zero_q, zero_d;
  logic             fs_d, fs_bout, load, last;
  logic [WIDTH-1:0] acc_nxt;

  full_subtractor u_fs (
    .A    (opa_q[0]),
    .B    (opb_q[0]),
    .Bin  (br_q),
    .D    (fs_d),
    .Bout (fs_bout)
  );

  // Difference bits enter at the MSB so the LSB lands at bit 0 after WIDTH shifts.
  assign acc_nxt = {fs_d, acc_q[WIDTH-1:1]};
  assign load    = Start && (state_q == IDLE || state_q == DONE);
  assign last    = (cnt_q == CW'(WIDTH - 1));

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      br_q    <= 1'b0;
      dres_q  <= '0;
      bout_q  <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      br_q    <= br_d;
      dres_q  <= dres_d;
      bout_q  <= bout_d;
      zero_q  <= zero_d;
    end
  end

  always_comb begin
    state_d = state_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    br_d    = br_q;
    dres_d  = dres_q;
    bout_d  = bout_q;
    zero_d  = zero_q;
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (load) begin
          state_d = SHIFT;
          opa_d   = A;
          opb_d   = B;
          br_d    = Bin;
          cnt_d   = '0;
          acc_d   = '0;
        end
      end
      SHIFT: begin
        opa_d = opa_q >> 1;
        opb_d = opb_q >> 1;
        br_d  = fs_bout;
        acc_d = acc_nxt;
        cnt_d = cnt_q + CW'(1);
        if (last) begin
          state_d = DONE;
          dres_d  = acc_nxt;
          bout_d  = fs_bout;
          zero_d  = (acc_nxt == '0);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign Busy = (state_q == SHIFT);
  assign Done = (state_q == DONE);
  assign D    = dres_q;
  assign Bout = bout_q;
  assign Zero = zero_q;
endmodule
